rf_sequencer: RTL and testbench
===============================

Name: rf_sequencer

Overview:
- Micro-sequencer that acts as the initiator on the 4-entry x 4-bit register file port set: it drives read selects, captures read data, computes a result, and drives the write port.
- Accepts one 8-bit instruction at a time over a valid/ready handshake.
- Sits between instruction fetch and the register file; it owns SEL_A, SEL_B, SEL_W, write_en and the write data bus.

Parameters:
- DW, 4, data width; must match the register file width.
- SETTLE, 0, extra READ-state cycles to cover register-file read-mux settling (0..3).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  INSTR is valid.
- INSTR  input  8  instruction: [7:6] op, [5:4] rd, [3:2] rs, [3:0] imm (LDI only).
- instr_ready  output  1  sequencer can accept an instruction.
- SEL_A  output  2  register file read select A (rd).
- SEL_B  output  2  register file read select B (rs).
- RD_A  input  DW  register file OUT_A.
- RD_B  input  DW  register file OUT_B.
- SEL_W  output  2  register file write select.
- write_en  output  1  register file write enable.
- DATA_W  output  DW  register file DATA_IN.
- done  output  1  one-cycle pulse marking the write cycle.
- C_FLAG  output  1  carry/borrow flag.
- Z_FLAG  output  1  zero flag.

Behaviour:
- States: IDLE, READ, EXEC, WRITE. State register and all outputs are registered, except instr_ready, which is (state==IDLE).
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - SEL_A, SEL_B, SEL_W, DATA_W = 0.
  - write_en, done, C_FLAG, Z_FLAG = 0.
  - Operand and instruction latches = 0.
  - Reset mid-operation drops write_en immediately. The pending write never occurs. No instruction is replayed.
- IDLE:
  - On instr_valid && instr_ready, latch INSTR and set SEL_A=rd, SEL_B=rs.
  - Go to EXEC if op==LDI, else go to READ.
  - With no instr_valid, remain in IDLE.
  - INSTR is ignored outside accepted handshakes.
- READ:
  - Lasts 1+SETTLE cycles, counted by an internal 2-bit counter.
  - On the last cycle, capture RD_A into opA and RD_B into opB, then go to EXEC.
- EXEC (1 cycle):
  - Compute the result and flags as below, register them into DATA_W and the flag outputs, then go to WRITE.
  - op 00 MOV: result=opB; C unchanged.
  - op 01 ADD: {C,result}=opA+opB, DW+1-bit sum.
  - op 10 SUB: result=opA-opB modulo 2^DW; C=1 iff opA<opB (borrow).
  - op 11 LDI: result=imm; C unchanged.
  - Z=(result==0) for every op.
- WRITE (1 cycle):
  - write_en=1, SEL_W=rd, DATA_W=result, done=1.
  - The register file captures at the closing edge.
  - Then write_en=0, done=0, and go to IDLE.
- Hold rules:
  - SEL_A and SEL_B hold from accept until the next accept.
  - SEL_W holds rd after WRITE.
  - DATA_W holds its last value.
- Latency from the accept edge to the write edge: 3+SETTLE cycles for MOV/ADD/SUB, 2 cycles for LDI.
- Throughput: the next accept can occur on the edge that ends WRITE+1, i.e. one IDLE cycle minimum between instructions.
- rd==rs is legal. Example: ADD r1,r1 doubles r1.
- Wrap-around: ADD 0xF+0x1 gives 0x0 with C=1, Z=1. SUB 0x0-0x1 gives 0xF with C=1, Z=0.
- instr_valid held high across an operation is not re-accepted until IDLE. An instruction held on the bus is therefore taken exactly once per IDLE visit. The producer must drop valid or change INSTR after acceptance.

Test Plan:
- Reset with instr_valid=1 and INSTR=0xC5 held -> no write during reset. After release, the instruction is accepted in the first IDLE cycle: LDI r0,5 writes r0=5 at accept+2 and done pulses once.
- LDI r1,0xF; LDI r2,0x1; ADD r1,r2 (INSTR 0x58) -> r1=0x0, C_FLAG=1, Z_FLAG=1. write_en is high exactly 1 cycle, 3 cycles after accept.
- LDI r3,0x3; LDI r0,0x5; SUB r3,r0 (0xB0) -> r3=0xE, C_FLAG=1, Z_FLAG=0. MOV r2,r3 (0x2C) -> r2=0xE, C_FLAG stays 1.
- SETTLE=2, ADD r1,r1 with r1=0x4 -> SEL_A=SEL_B=1 for 3 READ cycles, r1=0x8, write at accept+5.
- rst_n pulsed low during the EXEC state of an ADD -> write_en never asserts, the target register is unchanged, and the outputs read 0 asynchronously.
- Back-to-back valid with 4 queued instructions -> instr_ready high only in IDLE, each instruction accepted once, write_en pulses count = 4.

Source files
------------

// File: rtl/rf_sequencer.sv
// Micro-sequencer driving a 4-entry register file: accepts one instruction per
// handshake, reads operands, executes MOV/ADD/SUB/LDI and writes the result back.
module rf_sequencer #(
    parameter int DW     = 4,
    parameter int SETTLE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [7:0]    INSTR,
    output logic          instr_ready,
    output logic [1:0]    SEL_A,
    output logic [1:0]    SEL_B,
    input  logic [DW-1:0] RD_A,
    input  logic [DW-1:0] RD_B,
    output logic [1:0]    SEL_W,
    output logic          write_en,
    output logic [DW-1:0] DATA_W,
    output logic          done,
    output logic          C_FLAG,
    output logic          Z_FLAG
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [1:0] READ_LAST = 2'(SETTLE);
    localparam logic [1:0] OP_LDI    = 2'b11;

    state_t        state;
    state_t        next_state;
    logic [7:0]    instr_q;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [1:0]    cnt;
    logic          read_last;
    logic [DW:0]   alu_out;

    // Returns {carry, result}; MOV and LDI pass the old carry through.
    function automatic logic [DW:0] alu(input logic [1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic [DW-1:0] imm,
                                        input logic c_in);
        logic [DW:0] r;
        case (op)
            2'b00:   r = {c_in, b};
            2'b01:   r = {1'b0, a} + {1'b0, b};
            2'b10:   r = {1'b0, a} - {1'b0, b};
            default: r = {c_in, imm};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (instr_valid) next_state = (INSTR[7:6] == OP_LDI) ? EXEC : READ;
            READ:    if (read_last) next_state = EXEC;
            EXEC:    next_state = WRITE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        read_last   = (cnt == READ_LAST);
        alu_out     = alu(instr_q[7:6], opa, opb, DW'(instr_q[3:0]), C_FLAG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            SEL_A    <= '0;
            SEL_B    <= '0;
            SEL_W    <= '0;
            DATA_W   <= '0;
            write_en <= 1'b0;
            done     <= 1'b0;
            C_FLAG   <= 1'b0;
            Z_FLAG   <= 1'b0;
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= INSTR;
                        SEL_A   <= INSTR[5:4];
                        SEL_B   <= INSTR[3:2];
                        cnt     <= '0;
                    end
                end
                READ: begin
                    if (read_last) begin
                        opa <= RD_A;
                        opb <= RD_B;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                EXEC: begin
                    // Registered here so the write port is stable for the whole WRITE cycle.
                    DATA_W   <= alu_out[DW-1:0];
                    C_FLAG   <= alu_out[DW];
                    Z_FLAG   <= (alu_out[DW-1:0] == '0);
                    SEL_W    <= instr_q[5:4];
                    write_en <= 1'b1;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer: two instances (SETTLE=0 and SETTLE=2) each
// driving a behavioural 4x4 register file.
module tb_rf_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld [2];
    logic [7:0] ins [2];
    logic       rdy [2];
    logic       we  [2];
    logic       dn  [2];
    logic       cf  [2];
    logic       zf  [2];
    logic [1:0] sa  [2];
    logic [1:0] sb  [2];
    logic [1:0] sw  [2];
    logic [3:0] rda [2];
    logic [3:0] rdb [2];
    logic [3:0] dw  [2];
    logic [3:0] rf  [2][4] = '{default: '0};
    int wcnt [2] = '{0, 0};
    int dcnt [2] = '{0, 0};
    int acc  [2] = '{0, 0};
    int rdy_bad = 0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_sequencer #(.DW(4), .SETTLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(vld[0]), .INSTR(ins[0]),
        .instr_ready(rdy[0]), .SEL_A(sa[0]), .SEL_B(sb[0]), .RD_A(rda[0]),
        .RD_B(rdb[0]), .SEL_W(sw[0]), .write_en(we[0]), .DATA_W(dw[0]),
        .done(dn[0]), .C_FLAG(cf[0]), .Z_FLAG(zf[0]));

    rf_sequencer #(.DW(4), .SETTLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(vld[1]), .INSTR(ins[1]),
        .instr_ready(rdy[1]), .SEL_A(sa[1]), .SEL_B(sb[1]), .RD_A(rda[1]),
        .RD_B(rdb[1]), .SEL_W(sw[1]), .write_en(we[1]), .DATA_W(dw[1]),
        .done(dn[1]), .C_FLAG(cf[1]), .Z_FLAG(zf[1]));

    assign rda[0] = rf[0][sa[0]];
    assign rdb[0] = rf[0][sb[0]];
    assign rda[1] = rf[1][sa[1]];
    assign rdb[1] = rf[1][sb[1]];

    // Register file model plus event counters.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                if (we[k]) begin
                    rf[k][sw[k]] <= dw[k];
                    wcnt[k]++;
                end
                if (dn[k]) dcnt[k]++;
                if (vld[k] && rdy[k]) acc[k]++;
                if (rdy[k] && we[k]) rdy_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, check accept-to-write latency and the one-cycle write pulse.
    task automatic run(input int k, input logic [7:0] i_word, input int exp_lat,
                       input string tag, output int good);
        int lat;
        lat  = -1;
        good = 0;
        vld[k] = 1'b1;
        ins[k] = i_word;
        for (int n = 0; n < 20 && !rdy[k]; n++) tick();
        tick();
        vld[k] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sa[k] == i_word[5:4] && sb[k] == i_word[3:2]) good++;
            if (we[k]) begin
                lat = i + 1;
                break;
            end
            tick();
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, dn[k], 1'b1);
        tick();
        chk({tag, "_we_once"}, we[k], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int w0;
        logic [7:0] q [4];
        vld[0] = 1'b1;
        ins[0] = 8'hC5;
        vld[1] = 1'b0;
        ins[1] = 8'h00;

        // Reset with an instruction held on the bus.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_we", we[0], 1'b0);
        end
        chk("rst_sel_a", sa[0], 2'd0);
        chk("rst_sel_b", sb[0], 2'd0);
        chk("rst_sel_w", sw[0], 2'd0);
        chk("rst_data", dw[0], 4'd0);
        chk("rst_flags", {cf[0], zf[0], dn[0]}, 3'b000);
        chk("rst_ready", rdy[0], 1'b1);
        @(negedge clk) rst_n = 1'b1;
        run(0, 8'hC5, 2, "ldi_rst", g);
        chk("ldi_rst_r0", rf[0][0], 4'h5);
        chk("ldi_rst_done_cnt", dcnt[0], 1);
        chk("ldi_rst_acc_cnt", acc[0], 1);

        // ADD wrap-around F+1.
        run(0, 8'hDF, 2, "ldi_r1", g);
        run(0, 8'hE1, 2, "ldi_r2", g);
        chk("ldi_r2_val", rf[0][2], 4'h1);
        run(0, 8'h58, 3, "add", g);
        chk("add_r1", rf[0][1], 4'h0);
        chk("add_c", cf[0], 1'b1);
        chk("add_z", zf[0], 1'b1);

        // SUB with borrow, MOV keeps carry, SUB to zero clears carry.
        run(0, 8'hF3, 2, "ldi_r3", g);
        run(0, 8'hC5, 2, "ldi_r0", g);
        run(0, 8'hB0, 3, "sub", g);
        chk("sub_r3", rf[0][3], 4'hE);
        chk("sub_c", cf[0], 1'b1);
        chk("sub_z", zf[0], 1'b0);
        run(0, 8'h2C, 3, "mov", g);
        chk("mov_r2", rf[0][2], 4'hE);
        chk("mov_c_kept", cf[0], 1'b1);
        run(0, 8'h80, 3, "sub0", g);
        chk("sub0_r0", rf[0][0], 4'h0);
        chk("sub0_cz", {cf[0], zf[0]}, 2'b01);

        // SETTLE=2: ADD r1,r1 with r1=4.
        run(1, 8'hD4, 2, "s2_ldi", g);
        run(1, 8'h54, 5, "s2_add", g);
        chk("s2_sel_hold", g, 5);
        chk("s2_r1", rf[1][1], 4'h8);
        chk("s2_cz", {cf[1], zf[1]}, 2'b00);
        chk("s2_sel_after", {sa[1], sb[1]}, 4'b0101);

        // Reset asserted while an ADD r2,r3 is in EXEC.
        w0 = wcnt[0];
        vld[0] = 1'b1;
        ins[0] = 8'h6C;
        for (int n = 0; n < 20 && !rdy[0]; n++) tick();
        tick();
        vld[0] = 1'b0;
        tick();
        chk("mid_pre_we", we[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_data", dw[0], 4'h0);
        chk("mid_async_sel", {sa[0], sb[0], sw[0]}, 6'd0);
        chk("mid_async_ctl", {we[0], dn[0], cf[0], zf[0]}, 4'd0);
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_we", we[0], 1'b0);
        end
        chk("mid_wcnt", wcnt[0], w0);
        chk("mid_r2", rf[0][2], 4'hE);

        // Four queued instructions with valid held high throughout.
        w0 = wcnt[0];
        g  = acc[0];
        q[0] = 8'hC1;
        q[1] = 8'hD2;
        q[2] = 8'h44;
        q[3] = 8'h90;
        vld[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ins[0] = q[i];
            for (int n = 0; n < 20 && !rdy[0]; n++) tick();
            tick();
        end
        vld[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("q_writes", wcnt[0] - w0, 4);
        chk("q_accepts", acc[0] - g, 4);
        chk("q_ready_in_write", rdy_bad, 0);
        chk("q_r0", rf[0][0], 4'h3);
        chk("q_r1", rf[0][1], 4'hF);
        chk("q_c", cf[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
